aes_round_key_sequencer: RTL and testbench

- AES-256 round-key expansion and streaming stage. It sits directly upstream of AesBlockEncDec and drives that core's inKeyData0, inKeyData1, inDataWr, inDataData and inAesMode.
- It expands a 256-bit cipher key into round keys K0..K14 (FIPS-197), one round key per cycle, and stores them.
- On each block start it streams the keys in encrypt order or decrypt order, aligned with the data write strobe.

---
 rtl/aes_round_key_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_aes_round_key_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_key_sequencer.sv
// AES-256 round-key expansion and encrypt/decrypt key streaming for AesBlockEncDec.
// Optional macro AES_KEY_ZEROIZE_EN adds the inZeroize port (clears key store and outputs).
module aes_round_key_sequencer #(
  parameter int unsigned MIN_GAP = 0
) (
  input  logic         inClk,
  input  logic         inRstN,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic         inZeroize,
`endif
  input  logic         inKeyWr,
  input  logic [255:0] inKey,
  input  logic         inStart,
  input  logic         inMode,
  input  logic [127:0] inData,
  output logic         outReady,
  output logic         outBusy,
  output logic         outAesMode,
  output logic         outDataWr,
  output logic [127:0] outDataData,
  output logic [127:0] outKeyData0,
  output logic [127:0] outKeyData1
);

  typedef enum logic [2:0] {ST_IDLE, ST_EXPAND, ST_READY, ST_STREAM, ST_GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'((MIN_GAP == 0) ? 0 : MIN_GAP - 1);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? sh : 8'h00);
      sh  = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Forward S-box: multiplicative inverse as x^254 (= x^2*x^4*...*x^128), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] base;
    inv  = 8'h01;
    base = x;
    for (int i = 1; i < 8; i++) begin
      base = gf_mul(base, base);
      inv  = gf_mul(inv, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic           mode_q, mode_d;
  logic           data_wr_q, data_wr_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   key0_q, key0_d;
  logic [127:0]   key1_q, key1_d;
  logic [127:0]   key_q [15];

  logic           store_load_s;
  logic           store_exp_s;
  logic           store_zero_s;
  logic           restart_s;
  logic [127:0]   prev_key_s;
  logic [127:0]   prev2_key_s;
  logic [7:0]     rcon_s;
  logic [31:0]    temp_s;
  logic [127:0]   exp_key_s;
  logic [127:0]   stream_key_s;

  // Next round key K(cnt+1) from K(cnt) and K(cnt-1); odd cnt means even key index.
  always_comb begin
    prev_key_s  = key_q[cnt_q];
    prev2_key_s = key_q[cnt_q - 4'd1];
    rcon_s      = 8'h01 << cnt_q[3:1];
    if (cnt_q[0]) begin
      temp_s = sub_word({prev_key_s[23:0], prev_key_s[31:24]}) ^ {rcon_s, 24'h000000};
    end else begin
      temp_s = sub_word(prev_key_s[31:0]);
    end
    exp_key_s[127:96] = prev2_key_s[127:96] ^ temp_s;
    exp_key_s[95:64]  = prev2_key_s[95:64]  ^ exp_key_s[127:96];
    exp_key_s[63:32]  = prev2_key_s[63:32]  ^ exp_key_s[95:64];
    exp_key_s[31:0]   = prev2_key_s[31:0]   ^ exp_key_s[63:32];
    stream_key_s      = mode_q ? key_q[4'd13 - cnt_q] : key_q[cnt_q + 4'd1];
  end

  // Sequencer next-state and registered-output values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    ready_d      = ready_q;
    busy_d       = busy_q;
    mode_d       = mode_q;
    data_wr_d    = data_wr_q;
    data_d       = data_q;
    key0_d       = key0_q;
    key1_d       = key1_q;
    store_load_s = 1'b0;
    store_exp_s  = 1'b0;
    store_zero_s = 1'b0;
    restart_s    = inKeyWr && (state_q == ST_IDLE || state_q == ST_EXPAND || state_q == ST_READY);

    if (restart_s) begin
      store_load_s = 1'b1;
      state_d      = ST_EXPAND;
      cnt_d        = 4'd1;
      valid_d      = 1'b0;
      ready_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_EXPAND: begin
          store_exp_s = 1'b1;
          if (cnt_q == 4'd13) begin
            state_d = ST_READY;
            valid_d = 1'b1;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_READY: begin
          if (inStart && valid_q) begin
            state_d   = ST_STREAM;
            cnt_d     = 4'd1;
            ready_d   = 1'b0;
            busy_d    = 1'b1;
            data_wr_d = 1'b1;
            data_d    = inData;
            mode_d    = inMode;
            key0_d    = inMode ? key_q[14] : key_q[0];
            key1_d    = inMode ? key_q[13] : key_q[1];
          end else begin
            state_d = ST_READY;
          end
        end
        ST_STREAM: begin
          data_wr_d = 1'b0;
          data_d    = 128'h0;
          key1_d    = 128'h0;
          if (cnt_q == 4'd14) begin
            key0_d = 128'h0;
            busy_d = 1'b0;
            cnt_d  = 4'd0;
            if (MIN_GAP == 0) begin
              state_d = ST_READY;
              ready_d = 1'b1;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            key0_d = stream_key_s;
            cnt_d  = cnt_q + 4'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_READY;
            ready_d = 1'b1;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          ready_d = 1'b0;
        end
      endcase
    end

`ifdef AES_KEY_ZEROIZE_EN
    if (inZeroize) begin
      store_zero_s = 1'b1;
      store_load_s = 1'b0;
      store_exp_s  = 1'b0;
      state_d      = ST_IDLE;
      cnt_d        = 4'd0;
      valid_d      = 1'b0;
      ready_d      = 1'b0;
      busy_d       = 1'b0;
      mode_d       = 1'b0;
      data_wr_d    = 1'b0;
      data_d       = 128'h0;
      key0_d       = 128'h0;
      key1_d       = 128'h0;
    end else begin
      store_zero_s = 1'b0;
    end
`endif
  end

  // Control and output registers; reset aborts any expansion or stream.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      mode_q    <= 1'b0;
      data_wr_q <= 1'b0;
      data_q    <= 128'h0;
      key0_q    <= 128'h0;
      key1_q    <= 128'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      mode_q    <= mode_d;
      data_wr_q <= data_wr_d;
      data_q    <= data_d;
      key0_q    <= key0_d;
      key1_q    <= key1_d;
    end
  end

  // Key store: survives reset (only the valid flag is cleared); zeroize wipes it.
  always_ff @(posedge inClk) begin
    if (store_zero_s) begin
      for (int i = 0; i < 15; i++) key_q[i] <= 128'h0;
    end else if (store_load_s) begin
      key_q[0] <= inKey[255:128];
      key_q[1] <= inKey[127:0];
    end else if (store_exp_s) begin
      key_q[cnt_q + 4'd1] <= exp_key_s;
    end
  end

  assign outReady    = ready_q;
  assign outBusy     = busy_q;
  assign outAesMode  = mode_q;
  assign outDataWr   = data_wr_q;
  assign outDataData = data_q;
  assign outKeyData0 = key0_q;
  assign outKeyData1 = key1_q;

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
// Self-checking bench for aes_round_key_sequencer: FIPS-197 AES-256 vectors plus random keys/blocks
// against a word-level key-schedule model. Zeroize section built only with AES_KEY_ZEROIZE_EN.
module tb_aes_round_key_sequencer;

  logic         inClk = 1'b0;
  logic         inRstN;
  logic         inKeyWr;
  logic [255:0] inKey;
  logic         inStart;
  logic         inMode;
  logic [127:0] inData;
`ifdef AES_KEY_ZEROIZE_EN
  logic         inZeroize;
`endif
  logic         outReady, outBusy, outAesMode, outDataWr;
  logic [127:0] outDataData, outKeyData0, outKeyData1;

  aes_round_key_sequencer #(.MIN_GAP(0)) dut (
    .inClk(inClk), .inRstN(inRstN),
`ifdef AES_KEY_ZEROIZE_EN
    .inZeroize(inZeroize),
`endif
    .inKeyWr(inKeyWr), .inKey(inKey), .inStart(inStart), .inMode(inMode), .inData(inData),
    .outReady(outReady), .outBusy(outBusy), .outAesMode(outAesMode), .outDataWr(outDataWr),
    .outDataData(outDataData), .outKeyData0(outKeyData0), .outKeyData1(outKeyData1)
  );

  initial forever #5 inClk = ~inClk;

  int           checks = 0;
  int           failures = 0;
  logic [7:0]   sb [256];
  logic [127:0] rk [15];
  logic [127:0] cap_k0 [15];
  logic [127:0] cap_k1;

  localparam logic [255:0] SPEC_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge inClk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box by brute-force inverse search and bitwise affine transform.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  // Textbook FIPS-197 word schedule, Nk = 8, 60 words.
  task automatic expand_model(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i - 1];
      if (i % 8 == 0) begin
        rc = 8'(1 << (i / 8 - 1));
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i - 8] ^ t;
    end
    for (int k = 0; k < 15; k++) rk[k] = {w[4 * k], w[4 * k + 1], w[4 * k + 2], w[4 * k + 3]};
  endtask

  task automatic finish_expand();
    for (int e = 1; e <= 13; e++) begin
      step();
      check("ready_during_expand", outReady, 128'(e == 13));
    end
  endtask

  task automatic load_key(input logic [255:0] key);
    inKey = key; inKeyWr = 1'b1;
    step();
    inKeyWr = 1'b0;
    expand_model(key);
    check("ready_after_e0", outReady, 0);
    finish_expand();
  endtask

  // One block; poke (1..14) re-asserts inStart inside the stream, 0 means no poke.
  task automatic run_block(input logic mode, input logic [127:0] data, input int poke);
    int ord [15];
    for (int i = 0; i < 15; i++) ord[i] = mode ? 14 - i : i;
    inMode = mode; inData = data; inStart = 1'b1;
    step();
    inStart = 1'b0; inMode = ~mode; inData = ~data;
    cap_k0[0] = outKeyData0; cap_k1 = outKeyData1;
    check("s_busy", outBusy, 1);
    check("s_ready", outReady, 0);
    check("s_datawr", outDataWr, 1);
    check("s_data", outDataData, data);
    check("s_mode", outAesMode, mode);
    check("s_key0", outKeyData0, rk[ord[0]]);
    check("s_key1", outKeyData1, rk[ord[1]]);
    for (int t = 1; t <= 13; t++) begin
      if (t == poke) inStart = 1'b1;
      step();
      inStart = 1'b0;
      cap_k0[t] = outKeyData0;
      check("st_key0", outKeyData0, rk[ord[t + 1]]);
      check("st_key1", outKeyData1, 0);
      check("st_datawr", outDataWr, 0);
      check("st_data", outDataData, 0);
      check("st_busy", outBusy, 1);
      check("st_mode", outAesMode, mode);
    end
    if (poke == 14) inStart = 1'b1;
    step();
    inStart = 1'b0;
    cap_k0[14] = outKeyData0;
    check("end_key0", outKeyData0, 0);
    check("end_busy", outBusy, 0);
    check("end_ready", outReady, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, outReady, 0);
    check({tag, "_busy"}, outBusy, 0);
    check({tag, "_mode"}, outAesMode, 0);
    check({tag, "_datawr"}, outDataWr, 0);
    check({tag, "_data"}, outDataData, 0);
    check({tag, "_key0"}, outKeyData0, 0);
    check({tag, "_key1"}, outKeyData1, 0);
  endtask

  task automatic spec_vectors();
    run_block(1'b1, 128'h8ea2b7ca516745bfeafc49904b496089, 0);
    check("dec_s_key0", cap_k0[0], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    check("dec_s_key1", cap_k1, 128'h4e5a6699a9f24fe07e572baacdf8cdea);
    check("dec_s1_key0", cap_k0[1], 128'h2541fe719bf500258813bbd55a721c0a);
    check("dec_s13_key0", cap_k0[13], 128'h000102030405060708090a0b0c0d0e0f);
    run_block(1'b0, 128'h00112233445566778899aabbccddeeff, 0);
    check("enc_s_key0", cap_k0[0], 128'h000102030405060708090a0b0c0d0e0f);
    check("enc_s_key1", cap_k1, 128'h101112131415161718191a1b1c1d1e1f);
    check("enc_s1_key0", cap_k0[1], 128'ha573c29fa176c498a97fce93a572c09c);
    check("enc_s13_key0", cap_k0[13], 128'h24fc79ccbf0979e9371ac23c6d68de36);
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [255:0] k;
    build_sbox();
    inRstN = 1'b0; inKeyWr = 1'b0; inKey = '0; inStart = 1'b0; inMode = 1'b0; inData = '0;
`ifdef AES_KEY_ZEROIZE_EN
    inZeroize = 1'b0;
`endif
    #1;
    check_all_zero("reset");
    step(); step();
    inRstN = 1'b1;
    inStart = 1'b1;
    step();
    inStart = 1'b0;
    check("idle_start_ignored", outBusy, 0);

    // Expansion timing and FIPS-197 streams.
    load_key(SPEC_KEY);
    spec_vectors();

    // Simultaneous key write and start: key write wins.
    k = rand_key();
    inKey = k; inKeyWr = 1'b1; inStart = 1'b1; inMode = 1'b0;
    step();
    inKeyWr = 1'b0; inStart = 1'b0;
    expand_model(k);
    check("coll_busy", outBusy, 0);
    check("coll_datawr", outDataWr, 0);
    check("coll_ready", outReady, 0);
    finish_expand();
    run_block(1'($urandom_range(0, 1)), rand_blk(), 7);

    // Key write mid-expansion restarts with the new key.
    inKey = rand_key(); inKeyWr = 1'b1;
    step();
    inKeyWr = 1'b0;
    repeat (5) step();
    check("restart_ready", outReady, 0);
    load_key(rand_key());
    run_block(1'b1, rand_blk(), 0);
    run_block(1'b0, rand_blk(), 0);

    // Random keys and blocks with stray starts during the stream.
    for (int n = 0; n < 3; n++) begin
      load_key(rand_key());
      for (int b = 0; b < 3; b++) begin
        inKeyWr = 1'b0;
        run_block(1'($urandom_range(0, 1)), rand_blk(), int'($urandom_range(0, 14)));
      end
    end

    // Reset in the middle of a stream.
    inMode = 1'b1; inData = rand_blk(); inStart = 1'b1;
    step();
    inStart = 1'b0;
    repeat (5) step();
    inRstN = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    inRstN = 1'b1;
    inStart = 1'b1;
    step();
    inStart = 1'b0;
    check_all_zero("postrst");
    repeat (3) step();
    check("postrst_ready_hold", outReady, 0);
    load_key(SPEC_KEY);
    spec_vectors();

`ifdef AES_KEY_ZEROIZE_EN
    // Zeroize mid-stream, then a dropped start, then reload.
    inMode = 1'b0; inData = rand_blk(); inStart = 1'b1;
    step();
    inStart = 1'b0;
    repeat (2) step();
    inZeroize = 1'b1;
    step();
    inZeroize = 1'b0;
    check_all_zero("zeroize");
    inStart = 1'b1;
    step();
    inStart = 1'b0;
    check_all_zero("zeroize_start");
    load_key(SPEC_KEY);
    spec_vectors();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
